// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared PIO definitions for the instruction encoder: opcode constants,
//   instruction-memory geometry, FSM state encoding, the field-beat record and
//   a helper that flags side-set configurations too wide for the 5-bit
//   delay/side-set field.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);
  localparam int FIELD_W    = 5;  // shared delay/side-set field, instr[12:8]

  typedef enum logic [2:0] {
    OP_JMP       = 3'd0,
    OP_WAIT      = 3'd1,
    OP_IN        = 3'd2,
    OP_OUT       = 3'd3,
    OP_PUSH_PULL = 3'd4,
    OP_MOV       = 3'd5,
    OP_IRQ       = 3'd6,
    OP_SET       = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One instruction's worth of fields as presented on a beat.
  typedef struct packed {
    opcode_e    op;
    logic [2:0] op1;
    logic [4:0] op2;
    logic [4:0] delay;
    logic [4:0] side_set;
    logic       side_en;
  } beat_t;

  // Side-set data bits plus the optional enable flag must fit in FIELD_W.
  function automatic logic cfg_illegal(input logic [2:0] sideset_bits,
                                       input logic       sideset_enable_bit);
    return ({1'b0, sideset_bits} + {3'b000, sideset_enable_bit}) > 4'(FIELD_W);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//   Field-beat channel into the instruction encoder. The master presents the
//   instruction fields with in_valid; the slave (encoder) answers with
//   in_ready. A beat transfers on a clock edge where both are high.
//   Signals: in_valid, in_ready, op, op1, op2, delay, side_set, side_en.
// -----------------------------------------------------------------------------
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [2:0] op1;
  logic [4:0] op2;
  logic [4:0] delay;
  logic [4:0] side_set;
  logic       side_en;

  modport master (
    output in_valid, op, op1, op2, delay, side_set, side_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, op1, op2, delay, side_set, side_en,
    output in_ready
  );
endinterface

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Pure combinational packing of one beat into a 16-bit PIO instruction:
//     word[15:13] = op, word[12:8] = F, word[7:5] = op1, word[4:0] = op2
//   With T = sideset_bits + sideset_enable_bit and D = 5 - T, F holds the
//   side-set group (optional enable flag above the side-set data bits) in its
//   top T bits and the delay in its low D bits. Fields too wide for their slot
//   are truncated and reported on overflow.
// Ports:
//   sideset_bits, sideset_enable_bit  latched side-set configuration
//   beat                              instruction fields
//   word                              packed instruction
//   overflow                          delay or side_set did not fit
// -----------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  sideset_bits,
  input  logic        sideset_enable_bit,
  input  beat_t       beat,
  output logic [15:0] word,
  output logic        overflow
);

  logic [3:0]         total_bits;
  logic [2:0]         delay_bits;
  logic [5:0]         side_mask;
  logic [4:0]         delay_mask;
  logic [5:0]         side_val;
  logic [FIELD_W-1:0] field;

  // NOTE: every signal driven here gets an unconditional assignment before
  // any conditional update, so no path leaves a value held (no latch).
  always_comb begin
    total_bits = {1'b0, sideset_bits} + {3'b000, sideset_enable_bit};
    // Illegal configurations never reach a write; clamp D to keep shifts sane.
    delay_bits = (total_bits > 4'(FIELD_W)) ? 3'd0 : 3'(4'(FIELD_W) - total_bits);

    // With D = 5 the shift wraps to zero and the subtraction yields all ones,
    // which is exactly the full 5-bit delay mask.
    side_mask  = (6'd1 << sideset_bits) - 6'd1;
    delay_mask = (5'd1 << delay_bits) - 5'd1;

    side_val = {1'b0, beat.side_set} & side_mask;
    if (sideset_enable_bit) begin
      side_val = side_val | (6'(beat.side_en) << sideset_bits);
    end

    field    = 5'(side_val << delay_bits) | (beat.delay & delay_mask);
    overflow = (|(beat.delay & ~delay_mask)) |
               (|({1'b0, beat.side_set} & ~side_mask));
    word     = {beat.op, field, beat.op1, beat.op2};
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Loads a program into instruction memory: after start it accepts `length`
//   field beats, packs each into a 16-bit instruction and writes it to
//   (base_addr + index) mod 32, one instruction per two cycles at most.
//   Fields that overflow their slot are truncated and raise sticky err; an
//   impossible side-set configuration raises err and finishes with no writes.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   sideset_bits, sideset_enable_bit  side-set configuration (latched on start)
//   start, base_addr, length          program load request (length 0 = 32)
//   bus                               field-beat channel (slave side)
//   imem_we, imem_addr, imem_wdata    instruction-memory write port
//   busy, done, err                   status: not idle, end pulse, sticky error
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sideset_bits,
  input  logic              sideset_enable_bit,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        length,
  instr_encoder_if.slave    bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state;
  logic [2:0]        cfg_sideset_bits;
  logic              cfg_enable_bit;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] idx;
  logic              in_ready_q;
  beat_t             beat;
  logic [15:0]       packed_word;
  logic              pack_overflow;

  assign bus.in_ready = in_ready_q;

  always_comb begin
    beat.op       = opcode_e'(bus.op);
    beat.op1      = bus.op1;
    beat.op2      = bus.op2;
    beat.delay    = bus.delay;
    beat.side_set = bus.side_set;
    beat.side_en  = bus.side_en;
  end

  instr_pack u_pack (
    .sideset_bits       (cfg_sideset_bits),
    .sideset_enable_bit (cfg_enable_bit),
    .beat               (beat),
    .word               (packed_word),
    .overflow           (pack_overflow)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      in_ready_q       <= 1'b0;
      imem_we          <= 1'b0;
      imem_addr        <= '0;
      imem_wdata       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      cfg_sideset_bits <= '0;
      cfg_enable_bit   <= 1'b0;
      base_q           <= '0;
      last_idx         <= '0;
      idx              <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_sideset_bits <= sideset_bits;
            cfg_enable_bit   <= sideset_enable_bit;
            base_q           <= base_addr;
            // Truncating length-1 to 5 bits maps both 0 and 32 to index 31.
            last_idx         <= ADDR_W'(length - 6'd1);
            idx              <= '0;
            busy             <= 1'b1;
            if (cfg_illegal(sideset_bits, sideset_enable_bit)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              err        <= 1'b0;
              in_ready_q <= 1'b1;
              state      <= ST_ACCEPT;
            end
          end
        end

        ST_ACCEPT: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= base_q + idx;  // wraps mod IMEM_DEPTH by width
            imem_wdata <= packed_word;
            if (pack_overflow) begin
              err <= 1'b1;
            end
            state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          imem_we <= 1'b0;
          idx     <= idx + 1'b1;
          if (idx == last_idx) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            in_ready_q <= 1'b1;
            state      <= ST_ACCEPT;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder: a table of single-instruction loads
//   with hand-packed expected words, then directed sequences for address wrap,
//   configuration latching, ignored start, illegal configuration and reset
//   abort. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sideset_bits;
  logic        sideset_enable_bit;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  length;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk                (clk),
    .reset              (reset),
    .sideset_bits       (sideset_bits),
    .sideset_enable_bit (sideset_enable_bit),
    .start              (start),
    .base_addr          (base_addr),
    .length             (length),
    .bus                (bus),
    .imem_we            (imem_we),
    .imem_addr          (imem_addr),
    .imem_wdata         (imem_wdata),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sb;
    logic        en;
    logic [2:0]  op;
    logic [2:0]  op1;
    logic [4:0]  op2;
    logic [4:0]  dly;
    logic [4:0]  ss;
    logic        se;
    logic [15:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [2:0] sb, input logic en, input logic [2:0] op,
                              input logic [2:0] op1, input logic [4:0] op2, input logic [4:0] dly,
                              input logic [4:0] ss, input logic se, input logic [15:0] exp_word,
                              input logic exp_err);
    vec_t v;
    v.sb = sb; v.en = en; v.op = op; v.op1 = op1; v.op2 = op2;
    v.dly = dly; v.ss = ss; v.se = se; v.exp_word = exp_word; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive_beat(input vec_t v);
    bus.op       = v.op;
    bus.op1      = v.op1;
    bus.op2      = v.op2;
    bus.delay    = v.dly;
    bus.side_set = v.ss;
    bus.side_en  = v.se;
  endtask

  // One-instruction load: start, one beat, write, done, back to idle.
  task automatic run_one(input vec_t v, input int i);
    logic [4:0] base;
    base = 5'(i * 3 + 1);
    step();
    sideset_bits = v.sb; sideset_enable_bit = v.en;
    base_addr = base; length = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d_accept_busy", i), busy, 1);
    check($sformatf("v%0d_accept_ready", i), bus.in_ready, 1);
    check($sformatf("v%0d_err_cleared", i), err, 0);
    check($sformatf("v%0d_accept_we", i), imem_we, 0);
    drive_beat(v);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check($sformatf("v%0d_we", i), imem_we, 1);
    check($sformatf("v%0d_wdata", i), imem_wdata, v.exp_word);
    check($sformatf("v%0d_addr", i), imem_addr, base);
    check($sformatf("v%0d_err", i), err, v.exp_err);
    check($sformatf("v%0d_write_ready", i), bus.in_ready, 0);
    step();
    check($sformatf("v%0d_done", i), done, 1);
    check($sformatf("v%0d_done_we", i), imem_we, 0);
    step();
    check($sformatf("v%0d_done_pulse", i), done, 0);
    check($sformatf("v%0d_idle_busy", i), busy, 0);
    check($sformatf("v%0d_err_sticky", i), err, v.exp_err);
  endtask

  initial begin
    int         writes;
    int         dones;
    int         last_c;
    logic [4:0] wrap_addr [4];

    reset = 1'b1; start = 1'b0; sideset_bits = '0; sideset_enable_bit = 1'b0;
    base_addr = '0; length = '0; bus.in_valid = 1'b0;
    bus.op = '0; bus.op1 = '0; bus.op2 = '0; bus.delay = '0; bus.side_set = '0; bus.side_en = 1'b0;

    //          sb    en    op    op1   op2     dly     ss      se    word      err
    vecs[0] = mk(3'd2, 1'b0, 3'd7, 3'd0, 5'd1,  5'd3,  5'd2,  1'b0, 16'hF301, 1'b0);
    vecs[1] = mk(3'd1, 1'b1, 3'd0, 3'd0, 5'd5,  5'd2,  5'd1,  1'b1, 16'h1A05, 1'b0);
    vecs[2] = mk(3'd1, 1'b1, 3'd0, 3'd0, 5'd5,  5'd2,  5'd1,  1'b0, 16'h0A05, 1'b0);
    vecs[3] = mk(3'd3, 1'b0, 3'd1, 3'd2, 5'd3,  5'd4,  5'd0,  1'b0, 16'h2043, 1'b1);
    vecs[4] = mk(3'd0, 1'b0, 3'd3, 3'd5, 5'd31, 5'd31, 5'd0,  1'b0, 16'h7FBF, 1'b0);
    vecs[5] = mk(3'd2, 1'b0, 3'd5, 3'd1, 5'd0,  5'd1,  5'd5,  1'b0, 16'hA920, 1'b1);
    vecs[6] = mk(3'd4, 1'b1, 3'd6, 3'd7, 5'd2,  5'd0,  5'd10, 1'b1, 16'hDAE2, 1'b0);
    vecs[7] = mk(3'd5, 1'b0, 3'd2, 3'd0, 5'd0,  5'd1,  5'd21, 1'b0, 16'h5500, 1'b1);

    // Reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", imem_we, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i], i);
    end

    // Address wrap with in_valid held high; configuration changed after start
    // and a start pulse mid-load must both be ignored.
    wrap_addr[0] = 5'd30; wrap_addr[1] = 5'd31; wrap_addr[2] = 5'd0; wrap_addr[3] = 5'd1;
    step();
    sideset_bits = 3'd2; sideset_enable_bit = 1'b0;
    base_addr = 5'd30; length = 6'd4; start = 1'b1;
    drive_beat(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    start = 1'b0; sideset_bits = 3'd0; base_addr = 5'd5;
    writes = 0; dones = 0; last_c = -100;
    for (int c = 0; c < 20; c++) begin
      start = 1'b0;
      if (imem_we) begin
        if (writes < 4) begin
          check($sformatf("wrap_addr%0d", writes), imem_addr, wrap_addr[writes]);
          check($sformatf("wrap_wdata%0d", writes), imem_wdata, 16'hF301);
        end
        if (writes > 0) check($sformatf("wrap_gap%0d", writes), c - last_c, 2);
        last_c = c;
        writes++;
        if (writes == 2) start = 1'b1;
      end
      if (done) begin
        check("wrap_done_timing", c - last_c, 1);
        dones++;
      end
      step();
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("wrap_write_count", writes, 4);
    check("wrap_done_count", dones, 1);
    check("wrap_idle", busy, 0);

    // Illegal configuration: T = 6
    step();
    sideset_bits = 3'd5; sideset_enable_bit = 1'b1; base_addr = 5'd0; length = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("illegal_done", done, 1);
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 1);
    check("illegal_we", imem_we, 0);
    check("illegal_ready", bus.in_ready, 0);
    step();
    check("illegal_done_pulse", done, 0);
    check("illegal_idle", busy, 0);
    check("illegal_err_sticky", err, 1);
    check("illegal_we_after", imem_we, 0);

    // Reset after 2 of 5 writes
    sideset_bits = 3'd2; sideset_enable_bit = 1'b0; base_addr = 5'd0; length = 6'd5; start = 1'b1;
    drive_beat(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    start = 1'b0;
    check("abort_err_cleared", err, 0);
    writes = 0;
    for (int c = 0; c < 20 && writes < 2; c++) begin
      step();
      if (imem_we) writes++;
    end
    check("abort_writes_before", writes, 2);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_we", imem_we, 0);
    check("abort_done", done, 0);
    check("abort_ready", bus.in_ready, 0);
    check("abort_addr", imem_addr, 0);
    check("abort_wdata", imem_wdata, 0);
    base_addr = 5'd9; length = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_ready", bus.in_ready, 1);
    check("restart_no_done", done, 0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("restart_we", imem_we, 1);
    check("restart_addr", imem_addr, 9);
    step();
    check("restart_done", done, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
